// File: rtl/adam_pause_seq_if.sv
// Pause handshake bundle: upstream pause_req/pause_ack plus the per-target fan-out.
// master is the sequencer side; slave is the upstream manager and target group.
interface adam_pause_seq_if #(
  parameter int NO_TGTS = 4
);
  logic               pause_req;
  logic               pause_ack;
  logic [NO_TGTS-1:0] tgt_pause_req;
  logic [NO_TGTS-1:0] tgt_pause_ack;
  logic [NO_TGTS-1:0] tgt_timeout;

  modport master (
    input  pause_req, tgt_pause_ack,
    output pause_ack, tgt_pause_req, tgt_timeout
  );

  modport slave (
    output pause_req, tgt_pause_ack,
    input  pause_ack, tgt_pause_req, tgt_timeout
  );
endinterface

// File: rtl/adam_pause_seq.sv
// Pause sequencer: pauses targets in ascending order, resumes in descending order.
// Optional per-step watchdog enabled by defining ADAM_PAUSE_SEQ_TIMEOUT_EN.
module adam_pause_seq #(
  parameter int NO_TGTS        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic test,
  adam_pause_seq_if.master bus
);
  localparam int IW = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NO_TGTS-1);

  typedef enum logic [1:0] {RUN, PAUSING, PAUSED, RESUMING} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NO_TGTS-1:0] req_q, req_d;
  logic               ack_q, ack_d;
  logic               tmo;

  logic unused_test;
  assign unused_test = test;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    unique case (state_q)
      RUN: begin
        // Hold off until every target has released its ack from the last resume
        if (bus.pause_req && !(|bus.tgt_pause_ack)) begin
          state_d = PAUSING;
          idx_d   = '0;
          req_d   = NO_TGTS'(1);
        end
      end
      PAUSING: begin
        if (bus.tgt_pause_ack[idx_q] || tmo) begin
          if (idx_q == LAST) begin
            state_d = PAUSED;
          end else begin
            idx_d        = idx_q + 1'b1;
            req_d[idx_d] = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (!bus.pause_req) begin
          state_d     = RESUMING;
          idx_d       = LAST;
          req_d[LAST] = 1'b0;
        end
      end
      RESUMING: begin
        if (!bus.tgt_pause_ack[idx_q] || tmo) begin
          if (idx_q == '0) begin
            state_d = RUN;
          end else begin
            idx_d        = idx_q - 1'b1;
            req_d[idx_d] = 1'b0;
          end
        end
      end
      default: state_d = RUN;
    endcase
    // Upstream ack stays high until the resume sweep has fully unwound
    ack_d = (state_d == PAUSED) || (state_d == RESUMING);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      idx_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.pause_ack     = ack_q;
  assign bus.tgt_pause_req = req_q;

`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NO_TGTS-1:0] to_q, to_d;
  logic               waiting, missing;

  assign waiting = (state_q == PAUSING) || (state_q == RESUMING);
  assign missing = ((state_q == PAUSING)  && !bus.tgt_pause_ack[idx_q]) ||
                   ((state_q == RESUMING) &&  bus.tgt_pause_ack[idx_q]);
  assign tmo     = waiting && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    to_d  = to_q;
    if (waiting) begin
      if (state_d == state_q && idx_d == idx_q) cnt_d = cnt_q + 1'b1;
      if (tmo && missing) to_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      to_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.tgt_timeout = to_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign tmo             = 1'b0;
  assign bus.tgt_timeout = '0;
`endif
endmodule
